// File: rtl/sram_sqi_arbiter_pkg.sv
// Shared definitions for the SQI SRAM arbiter: commands, FSM states, phase lengths.
// Latency: n/a (constants, types and one helper function only).
// Backpressure: n/a.
package sram_sqi_arbiter_pkg;

  localparam logic [7:0] SQI_EQIO_CMD  = 8'h38;
  localparam logic [7:0] SQI_WRITE_CMD = 8'h02;
  localparam logic [7:0] SQI_READ_CMD  = 8'h03;

  localparam int unsigned INIT_BITS     = 8;
  localparam int unsigned CMD_NIBBLES   = 2;
  localparam int unsigned ADDR_NIBBLES  = 6;
  localparam int unsigned DUMMY_NIBBLES = 2;
  localparam int unsigned DATA_NIBBLES  = 2;
  localparam int unsigned GAP_CLKS      = 2;

  typedef enum logic [2:0] {
    S_INIT  = 3'd0,
    S_IDLE  = 3'd1,
    S_CMD   = 3'd2,
    S_ADDR  = 3'd3,
    S_DUMMY = 3'd4,
    S_DATA  = 3'd5,
    S_GAP   = 3'd6
  } state_t;

  // Final phase-counter value of each state; every nibble takes two clocks.
  // INIT: one idle clock after reset, 16 shift clocks, then the CS-high gap.
  function automatic logic [4:0] state_last_cnt(input state_t s);
    case (s)
      S_INIT:  return 5'(2 * INIT_BITS + GAP_CLKS);
      S_CMD:   return 5'(2 * CMD_NIBBLES - 1);
      S_ADDR:  return 5'(2 * ADDR_NIBBLES - 1);
      S_DUMMY: return 5'(2 * DUMMY_NIBBLES - 1);
      S_DATA:  return 5'(2 * DATA_NIBBLES - 1);
      S_GAP:   return 5'(GAP_CLKS - 1);
      default: return 5'd0;
    endcase
  endfunction

endpackage

// File: rtl/sram_sqi_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter; the port granted last loses the next tie.
// Latency: combinational grant, pointer updates on the edge where adv_i accepts a grant.
// Backpressure: grant is held off externally by keeping adv_i low.
// Ports: clk_i/rst_i (sync, active high), req_i[1:0], adv_i, gnt_o[1:0] one-hot.
module rr_arbiter2 (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic       adv_i,
  output logic [1:0] gnt_o
);

  // 1 = port 1 was granted last; reset value gives port 0 first priority.
  logic last_q;

  always_comb begin
    gnt_o = req_i;
    if (req_i == 2'b11) gnt_o = last_q ? 2'b01 : 2'b10;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)                    last_q <= 1'b1;
    else if (adv_i && |req_i)     last_q <= gnt_o[1];
  end

endmodule

// File: rtl/sram_sqi_arbiter.sv
// Shares two SQI SRAMs between two byte requesters; runs EQIO init then single-byte transactions.
// Latency: write 20 CS-low clocks, read 24, rvalid 24 clocks after gnt, 2-clock gap before IDLE.
// Backpressure: requesters hold req until a gnt pulse; requests wait while busy or not ready.
// Ports: p0_*/p1_* request/grant/read-return, ready, sram_clock, sram0_cs/sram1_cs (active low),
//        sio_o/sio_oe shared SIO drive, sram0_sio_i/sram1_sio_i per-chip SIO inputs.
module sram_sqi_arbiter
  import sram_sqi_arbiter_pkg::*;
#(
  parameter int          ADDR_WIDTH = 18,
  parameter logic [7:0]  EQIO_CMD   = SQI_EQIO_CMD,
  parameter logic [7:0]  WRITE_CMD  = SQI_WRITE_CMD,
  parameter logic [7:0]  READ_CMD   = SQI_READ_CMD
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  p0_req,
  input  logic                  p0_we,
  input  logic [ADDR_WIDTH-1:0] p0_addr,
  input  logic [7:0]            p0_wdata,
  output logic                  p0_gnt,
  output logic [7:0]            p0_rdata,
  output logic                  p0_rvalid,
  input  logic                  p1_req,
  input  logic                  p1_we,
  input  logic [ADDR_WIDTH-1:0] p1_addr,
  input  logic [7:0]            p1_wdata,
  output logic                  p1_gnt,
  output logic [7:0]            p1_rdata,
  output logic                  p1_rvalid,
  output logic                  ready,
  output logic                  sram_clock,
  output logic                  sram0_cs,
  output logic                  sram1_cs,
  output logic [3:0]            sio_o,
  output logic                  sio_oe,
  input  logic [3:0]            sram0_sio_i,
  input  logic [3:0]            sram1_sio_i
);

  state_t                  state_q, state_d;
  logic [4:0]              cnt_q, cnt_d;
  logic                    we_q, sel_q, port_q;
  logic [ADDR_WIDTH-2:0]   addr_q;
  logic [7:0]              wdata_q;
  logic [3:0]              rhi_q;
  logic [7:0]              rdata0_q, rdata1_q;
  logic                    gnt0_q, gnt1_q, rv0_q, rv1_q;

  logic [1:0]              req, win;
  logic                    arb_adv;
  logic [3:0]              sio_in;
  logic [23:0]             addr24;
  logic [7:0]              cmd;
  logic [2:0]              nib_idx;
  logic [4:0]              init_off;
  logic [2:0]              init_idx;

  assign req     = {p1_req, p0_req};
  assign arb_adv = (state_q == S_IDLE) && (|req);
  assign sio_in  = sel_q ? sram1_sio_i : sram0_sio_i;
  assign addr24  = {{(25 - ADDR_WIDTH){1'b0}}, addr_q};
  assign cmd     = we_q ? WRITE_CMD : READ_CMD;
  assign nib_idx = cnt_q[3:1];

  rr_arbiter2 u_arb (
    .clk_i (clock),
    .rst_i (reset),
    .req_i (req),
    .adv_i (arb_adv),
    .gnt_o (win)
  );

  // Next state: every state except IDLE runs a fixed number of clocks.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 5'd1;
    if (state_q == S_IDLE) begin
      cnt_d = 5'd0;
      if (|req) state_d = S_CMD;
    end else if (cnt_q == state_last_cnt(state_q)) begin
      cnt_d = 5'd0;
      case (state_q)
        S_INIT:  state_d = S_IDLE;
        S_CMD:   state_d = S_ADDR;
        S_ADDR:  state_d = we_q ? S_DATA : S_DUMMY;
        S_DUMMY: state_d = S_DATA;
        S_DATA:  state_d = S_GAP;
        S_GAP:   state_d = S_IDLE;
        default: state_d = S_INIT;
      endcase
    end
  end

  // Pin decode; sram_clock is the low bit of the phase counter (LO then HI).
  always_comb begin
    sram_clock = 1'b0;
    sram0_cs   = 1'b1;
    sram1_cs   = 1'b1;
    sio_o      = 4'h0;
    sio_oe     = 1'b0;
    init_off   = cnt_q - 5'd1;
    init_idx   = init_off[3:1];
    case (state_q)
      S_INIT: begin
        // Count 0 is a quiet clock so pins are idle straight out of reset.
        if (cnt_q >= 5'd1 && cnt_q <= 5'(2 * INIT_BITS)) begin
          sram0_cs   = 1'b0;
          sram1_cs   = 1'b0;
          sio_oe     = 1'b1;
          sram_clock = init_off[0];
          sio_o[0]   = EQIO_CMD[3'd7 - init_idx];
        end
      end
      S_CMD, S_ADDR, S_DUMMY, S_DATA: begin
        sram0_cs   = sel_q;
        sram1_cs   = ~sel_q;
        sram_clock = cnt_q[0];
        if (state_q == S_CMD) begin
          sio_oe = 1'b1;
          sio_o  = (nib_idx == 3'd0) ? cmd[7:4] : cmd[3:0];
        end else if (state_q == S_ADDR) begin
          sio_oe = 1'b1;
          case (nib_idx)
            3'd0:    sio_o = addr24[23:20];
            3'd1:    sio_o = addr24[19:16];
            3'd2:    sio_o = addr24[15:12];
            3'd3:    sio_o = addr24[11:8];
            3'd4:    sio_o = addr24[7:4];
            default: sio_o = addr24[3:0];
          endcase
        end else if (state_q == S_DATA && we_q) begin
          sio_oe = 1'b1;
          sio_o  = (nib_idx == 3'd0) ? wdata_q[7:4] : wdata_q[3:0];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_INIT;
      cnt_q    <= 5'd0;
      we_q     <= 1'b0;
      sel_q    <= 1'b0;
      port_q   <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= 8'h00;
      rhi_q    <= 4'h0;
      rdata0_q <= 8'h00;
      rdata1_q <= 8'h00;
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      rv0_q    <= 1'b0;
      rv1_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gnt0_q  <= arb_adv & win[0];
      gnt1_q  <= arb_adv & win[1];
      rv0_q   <= 1'b0;
      rv1_q   <= 1'b0;
      if (arb_adv) begin
        we_q    <= win[1] ? p1_we    : p0_we;
        wdata_q <= win[1] ? p1_wdata : p0_wdata;
        addr_q  <= win[1] ? p1_addr[ADDR_WIDTH-2:0] : p0_addr[ADDR_WIDTH-2:0];
        sel_q   <= win[1] ? p1_addr[ADDR_WIDTH-1]   : p0_addr[ADDR_WIDTH-1];
        port_q  <= win[1];
      end
      // Read nibbles are taken on the edge that closes each HI phase.
      if (state_q == S_DATA && !we_q && cnt_q[0]) begin
        if (!cnt_q[1]) begin
          rhi_q <= sio_in;
        end else if (port_q) begin
          rdata1_q <= {rhi_q, sio_in};
          rv1_q    <= 1'b1;
        end else begin
          rdata0_q <= {rhi_q, sio_in};
          rv0_q    <= 1'b1;
        end
      end
    end
  end

  assign ready     = (state_q == S_IDLE);
  assign p0_gnt    = gnt0_q;
  assign p1_gnt    = gnt1_q;
  assign p0_rvalid = rv0_q;
  assign p1_rvalid = rv1_q;
  assign p0_rdata  = rdata0_q;
  assign p1_rdata  = rdata1_q;

endmodule

// File: doc/sram_sqi_arbiter.md
Name: sram_sqi_arbiter

Overview:
- Shares the two quad-SPI (SQI) capture SRAMs between two byte-wide requesters: port 0 is the MCU memory-controller bridge and port 1 is the capture/sampling engine.
- Arbitrates between the ports round-robin and sequences each single-byte SQI transaction: command, 24-bit address, dummy (read only), then data.
- Sends the one-time serial EQIO switch to both SRAMs after reset.
- Sits between the mc_* register bridge / capture logic and the sram_clock, sram0_cs, sram1_cs and sram*_sio pins of top.

Parameters:
- ADDR_WIDTH, 18, requester byte address width; MSB selects SRAM1, the lower ADDR_WIDTH-1 bits are the in-chip address.
- EQIO_CMD, 8'h38, serial command that enters SQI mode.
- WRITE_CMD, 8'h02, SQI write command.
- READ_CMD, 8'h03, SQI read command.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- p0_req  in  1  port 0 request; held high until p0_gnt
- p0_we  in  1  1 = write, 0 = read; sampled on grant
- p0_addr  in  ADDR_WIDTH  byte address; sampled on grant
- p0_wdata  in  8  write data; sampled on grant
- p0_gnt  out  1  one-cycle pulse when port 0 is accepted
- p0_rdata  out  8  read data; valid while p0_rvalid
- p0_rvalid  out  1  one-cycle pulse when read data is returned
- p1_req, p1_we, p1_addr, p1_wdata, p1_gnt, p1_rdata, p1_rvalid  same widths and meaning, port 1
- ready  out  1  high once EQIO init is complete and the FSM is in IDLE
- sram_clock  out  1  SRAM serial clock, shared by both chips
- sram0_cs  out  1  SRAM0 chip select, active low
- sram1_cs  out  1  SRAM1 chip select, active low
- sio_o  out  4  SIO output nibble, shared by both chips
- sio_oe  out  1  SIO output enable; top tristates sram0_sio/sram1_sio from this
- sram0_sio_i  in  4  SRAM0 SIO input
- sram1_sio_i  in  4  SRAM1 SIO input

Behaviour:
- Reset values: sram_clock=0, cs=1 on both chips, sio_o=0, sio_oe=0, gnt=0, rvalid=0, rdata=0, ready=0.
- Reset taken mid-transaction aborts it: no gnt/rvalid is issued and the FSM restarts at INIT.
- Serial timing: sram_clock = clock/2.
  - Each bit or nibble occupies 2 clocks: LO phase (sram_clock=0, drive sio_o), then HI phase (sram_clock=1).
  - Input is sampled on the clock edge that ends the HI phase.
- States: INIT, IDLE, CMD, ADDR, DUMMY, DATA, GAP.
- INIT:
  - Both CS low, sio_oe=1.
  - EQIO_CMD is shifted MSB first on sio_o[0]: 8 bits, 16 clocks.
  - Then both CS high for 2 clocks, then IDLE with ready=1.
- IDLE: if any req is high, the arbiter picks a winner on that edge.
  - Next cycle: gnt pulses for the winner, the selected CS goes low, the FSM enters CMD.
  - Winner's we, addr and wdata are latched.
- CMD: 2 nibbles, MSB nibble first, sio_oe=1.
- ADDR: 6 nibbles of {pad zeros, addr[ADDR_WIDTH-2:0]} as 24 bits, MSB first.
- DUMMY (read only): 2 nibbles; sio_oe drops to 0 at the start of DUMMY.
- DATA:
  - Write: 2 nibbles drive wdata, high nibble first.
  - Read: capture the high then the low nibble from the selected chip's sio_i.
- GAP: CS high, sram_clock=0, sio_oe=0 for 2 clocks, then IDLE.
  - For a read, rdata and rvalid are driven on the first GAP cycle.
- Latency, with grant edge = T:
  - Write: CS low on T+1..T+20, GAP T+21..T+22, next grant possible at edge T+23.
  - Read: CS low on T+1..T+24, rvalid at T+25, next grant at T+27.
- Arbitration: 2-way round-robin; the port granted last has lower priority; after reset port 0 has priority.
  - A single requester is always granted.
  - Simultaneous requests alternate.
  - A request arriving during a transaction waits for IDLE.
  - Requests are ignored while ready=0.
- Exactly one CS is ever low outside INIT.
- rdata holds its value until the next read completes on that port.

Decomposition:
- Shared include/package sram_sqi_defs: command constants, state encoding, nibble counts per state (CMD 2, ADDR 6, DUMMY 2, DATA 2, GAP 2 clocks).
- Sub-module rr_arbiter2: 2 req in, one-hot grant out, last-grant pointer, advance enable.

Test Plan:
- Reset release -> 16 clocks with both CS low, sio_o[0] sequence 0,0,1,1,1,0,0,0 (0x38) on LO phases; ready=1 after the 2-clock CS-high gap.
- p0 write addr 18'h00012, data 8'hA5 -> sram0_cs low 20 clocks; nibbles 0,2,0,0,0,0,1,2,A,5; p0_gnt one pulse; sram1_cs stays high.
- p1 read addr 18'h20034, SRAM1 model returns 8'h3C -> nibbles 0,3,0,0,0,0,3,4 out; sio_oe low from DUMMY; p1_rvalid at T+25 with p1_rdata=8'h3C.
- p0 and p1 both held high for 4 transactions -> grants in order p0,p1,p0,p1; no overlapping CS.
- Reset asserted at cycle 8 of a read -> both CS high and sio_oe=0 next cycle, no p*_rvalid, INIT EQIO sequence repeats.
- Request while ready=0, or p1 request arriving mid-write -> no gnt until IDLE; p1 is granted at edge T+23.
